fp_norm_pipe: RTL

//  Parametrised 2-stage FP normaliser; successor to the fixed 1-bit-shift divider normalise stage.

---
 rtl/fp_norm_pipe.sv | 150 +++++++++++++++
 1 files changed

// File: rtl/fp_norm_pipe.sv
// Two-stage floating-point normaliser: leading-zero count plus exponent adjust, with zero/underflow/overflow flags.
// Define FP_NORM_ROUND_EN to round to nearest-even in stage 2; otherwise G/R/S are truncated.
module fp_norm_pipe #(
    parameter int MANT_W  = 24,
    parameter int EXP_W   = 9,
    parameter int EXP_MAX = 255
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic              sign_in,
    input  logic [EXP_W-1:0]  exp_in,
    input  logic [MANT_W:0]   mant_in,
    input  logic [2:0]        grs_in,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              sign_out,
    output logic [EXP_W-1:0]  exp_out,
    output logic [MANT_W-1:0] mant_out,
    output logic              flag_zero,
    output logic              flag_uf,
    output logic              flag_of
);

    localparam int V_W   = MANT_W + 4;
    localparam int LZC_W = $clog2(MANT_W);
    localparam int E_W   = EXP_W + 2;
    localparam logic signed [E_W-1:0] EMAX_S = E_W'(EXP_MAX);

    function automatic logic [LZC_W-1:0] lzc_f(input logic [MANT_W-1:0] m);
        logic [LZC_W-1:0] n;
        n = '0;
        for (int i = 0; i < MANT_W; i++)
            if (m[i]) n = LZC_W'(MANT_W - 1 - i);
        return n;
    endfunction

    logic              adv;
    logic              s1_valid;
    logic [V_W-1:0]    s1_v;
    logic [LZC_W-1:0]  s1_lzc;
    logic              s1_sign;
    logic [EXP_W:0]    s1_exp;
    logic              s1_zero;

    logic [V_W-1:0]    v_in, v1;
    logic [EXP_W:0]    e1;
    logic [LZC_W-1:0]  lzc1;

    assign adv      = !out_valid || out_ready;
    assign in_ready = adv;

    // A carry means the value is >= 2.0: drop one bit into sticky and bump the exponent.
    always_comb begin
        v_in = {mant_in, grs_in};
        if (mant_in[MANT_W]) begin
            v1   = {1'b0, v_in[V_W-1:2], v_in[1] | v_in[0]};
            e1   = {1'b0, exp_in} + (EXP_W+1)'(1);
            lzc1 = '0;
        end else begin
            v1   = v_in;
            e1   = {1'b0, exp_in};
            lzc1 = lzc_f(mant_in[MANT_W-1:0]);
        end
    end

    logic [V_W-1:0]          v2;
    logic [MANT_W-1:0]       mant2, mant_f, mant_n;
    logic signed [E_W-1:0]   e2, e_f;
    logic [EXP_W-1:0]        exp_n;
    logic                    z_n, uf_n, of_n;
`ifdef FP_NORM_ROUND_EN
    logic                    inc;
    logic [MANT_W:0]         sum;
`else
    logic                    unused_grs;
`endif

    always_comb begin
        v2    = s1_v << s1_lzc;
        mant2 = v2[MANT_W+2:3];
        e2    = $signed({1'b0, s1_exp}) - $signed(E_W'(s1_lzc));
`ifdef FP_NORM_ROUND_EN
        inc = v2[2] && (v2[1] || v2[0] || mant2[0]);
        sum = {1'b0, mant2} + (MANT_W+1)'(inc);
        if (sum[MANT_W]) begin
            mant_f = {1'b1, {(MANT_W-1){1'b0}}};
            e_f    = e2 + $signed(E_W'(1));
        end else begin
            mant_f = sum[MANT_W-1:0];
            e_f    = e2;
        end
`else
        unused_grs = ^v2[2:0];
        mant_f     = mant2;
        e_f        = e2;
`endif
        mant_n = '0;
        exp_n  = '0;
        z_n    = 1'b0;
        uf_n   = 1'b0;
        of_n   = 1'b0;
        // Underflow is judged before rounding; overflow after, so a round-up can still saturate to Inf.
        if (s1_zero) begin
            z_n = 1'b1;
        end else if (e2 <= $signed(E_W'(0))) begin
            uf_n = 1'b1;
        end else if (e_f >= EMAX_S) begin
            of_n  = 1'b1;
            exp_n = EXP_W'(EXP_MAX);
        end else begin
            mant_n = mant_f;
            exp_n  = e_f[EXP_W-1:0];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_valid  <= 1'b0;
            s1_v      <= '0;
            s1_lzc    <= '0;
            s1_sign   <= 1'b0;
            s1_exp    <= '0;
            s1_zero   <= 1'b0;
            out_valid <= 1'b0;
            sign_out  <= 1'b0;
            exp_out   <= '0;
            mant_out  <= '0;
            flag_zero <= 1'b0;
            flag_uf   <= 1'b0;
            flag_of   <= 1'b0;
        end else if (adv) begin
            s1_valid  <= in_valid;
            s1_v      <= v1;
            s1_lzc    <= lzc1;
            s1_sign   <= sign_in;
            s1_exp    <= e1;
            s1_zero   <= (mant_in == '0);
            out_valid <= s1_valid;
            sign_out  <= s1_sign;
            exp_out   <= exp_n;
            mant_out  <= mant_n;
            flag_zero <= z_n;
            flag_uf   <= uf_n;
            flag_of   <= of_n;
        end
    end

endmodule
